foo_stream_fifo: RTL and testbench
==================================

Name: foo_stream_fifo

Overview:
- Synchronous valid/ready FIFO carrying 4-bit packed enum-typed `foo` words.
- Sits directly upstream of the `foo` pass-through stage and drives that stage's `inp` bus from `out_data`.
- Decouples the producer from the consumer with DEPTH entries of buffering.
- Exposes an occupancy count and a flush control.

Parameters:
- WIDTH, 4: bit width of one packed `foo` word; encoding 4'h0 = fOO.
- DEPTH, 4: number of storage entries; power of two, ≥ 2.
- CW, $clog2(DEPTH)+1: width of `count`; derived, must not be overridden.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- flush, input, 1: synchronous clear of contents; reset is not required.
- in_valid, input, 1: producer presents `in_data`.
- in_ready, output, 1: FIFO accepts a word this cycle.
- in_data, input, WIDTH: `foo` word to enqueue.
- out_valid, output, 1: `out_data` holds the head word.
- out_ready, input, 1: consumer takes the head word this cycle.
- out_data, output, WIDTH: head word; feeds downstream `inp`.
- count, output, CW: current occupancy, 0..DEPTH.

Behaviour:
- Interface (already decided): one clock `clk`; reset `rst` is synchronous and active-high.
- Push = in_valid & in_ready. Pop = out_valid & out_ready.
- in_ready = (count != DEPTH). It is combinational from state only and never depends on out_ready (no write-through when full).
- out_valid = (count != 0).
- out_data = storage[rd_ptr] when out_valid, else 4'h0 (fOO). No X is ever driven.
- Latency: a word pushed at edge N is visible on out_data/out_valid after edge N; it can be popped at edge N+1 at the earliest.
- Pointers: wr_ptr and rd_ptr are log2(DEPTH) bits and wrap modulo DEPTH naturally.
- Count update:
  - push only: count + 1.
  - pop only: count − 1.
  - push and pop together: unchanged; both pointers advance.
- Full (count == DEPTH): in_ready = 0; a pop may still occur; the write slot reopens on the next cycle.
- Empty (count == 0): out_valid = 0; out_ready is ignored; no pointer movement from out_ready.
- Ordering: strict FIFO order, with no reordering and no loss of accepted words.
- rst = 1 at an edge:
  - wr_ptr = rd_ptr = 0, count = 0.
  - Outputs after the edge: in_ready = 1, out_valid = 0, out_data = 0, count = 0.
  - Storage contents need not be cleared.
- flush = 1 at an edge: same effect as rst on pointers and count; any push or pop that cycle is discarded.
- rst and flush together: rst semantics apply (identical result).
- Reset or flush mid-stream: all buffered words are dropped, and the next accepted word is the first word out.
- in_data is treated as an opaque packed vector: no legality check on enum encodings, all 16 values pass unchanged.

Optional Feature:
- Macro: FOO_STREAM_FIFO_BYPASS_EN.
- Defined:
  - When count == 0 and in_valid = 1: out_valid = 1 and out_data = in_data combinationally.
  - If out_ready = 1 as well: the word passes through with zero latency; it is not stored, and pointers and count stay unchanged.
  - If out_ready = 0: the word is stored as normal.
- Not defined: exactly the baseline behaviour above, with one-cycle minimum latency; out_valid depends only on state.

Test Plan:
- Reset then idle → in_ready = 1, out_valid = 0, out_data = 4'h0, count = 0 for 5 cycles.
- Push 4'h3, 4'h5, 4'h9, 4'hC with out_ready = 0 → count = 4, in_ready = 0; a further push of 4'hF is not accepted. Then out_ready = 1 for 4 cycles → out_data 3, 5, 9, C in order, then out_valid = 0.
- Fill to 3 entries, then hold in_valid = out_ready = 1 for 10 cycles with an incrementing pattern → count stays 3, output sequence is the input sequence delayed by 3 pops, and the pointer wrap-around is exercised.
- Full FIFO, out_ready = 1, in_valid = 1 → pop that cycle, in_ready = 0; next cycle in_ready = 1, push accepted, count returns to 4.
- Push 4'h7, 4'h8, assert flush for one cycle with in_valid = 1 and in_data = 4'hA → count = 0, out_valid = 0, 4'hA not stored. The next push of 4'h1 is read first.
- With FOO_STREAM_FIFO_BYPASS_EN: empty FIFO, in_valid = out_ready = 1, in_data = 4'h6 → out_valid = 1 and out_data = 4'h6 in the same cycle, count stays 0. Without the macro: out_valid = 0 that cycle, and 4'h6 appears the next cycle.

Source files
------------

// File: rtl/foo_stream_fifo.sv
// Valid/ready FIFO for packed 4-bit `foo` words, feeding the downstream `inp` bus.
// Optional zero-latency pass-through when empty: define FOO_STREAM_FIFO_BYPASS_EN.
module foo_stream_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1  // derived; leave at default
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic             empty;
  logic             full;
  logic             bypass;
  logic             push;
  logic             pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign in_ready = ~full;
  assign count    = count_q;

`ifdef FOO_STREAM_FIFO_BYPASS_EN
  // An empty FIFO forwards the producer's word; it is only stored if the consumer stalls.
  assign bypass    = empty & in_valid & out_ready;
  assign out_valid = ~empty | in_valid;
  assign out_data  = ~empty ? mem[rd_ptr] : (in_valid ? in_data : '0);
`else
  assign bypass    = 1'b0;
  assign out_valid = ~empty;
  assign out_data  = ~empty ? mem[rd_ptr] : '0;
`endif

  assign push = in_valid & ~full & ~bypass;
  assign pop  = ~empty & out_ready;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage is never cleared; a push coinciding with rst or flush is discarded.
  always_ff @(posedge clk) begin
    if (push && !rst && !flush) mem[wr_ptr] <= in_data;
  end

endmodule

// File: tb/tb_foo_stream_fifo.sv
// Bench for foo_stream_fifo: directed plan plus random traffic against a queue model.
// Honours FOO_STREAM_FIFO_BYPASS_EN when the design is built with it.
module tb_foo_stream_fifo;

  localparam int WIDTH = 4;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;
`ifdef FOO_STREAM_FIFO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic [CW-1:0]    count;

  int n_asserts = 0;
  int n_fail    = 0;

  logic [WIDTH-1:0] q[$];

  foo_stream_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: compare outputs against the queue model mid-cycle, then advance the model.
  task automatic cyc(input string tag);
    logic       e_ready, e_valid, pass_thru, do_push, do_pop;
    logic [3:0] e_data;
    @(negedge clk);
    e_ready   = (q.size() != DEPTH);
    pass_thru = BYP && (q.size() == 0) && in_valid;
    e_valid   = (q.size() != 0) || pass_thru;
    e_data    = (q.size() != 0) ? q[0] : (pass_thru ? in_data : 4'h0);
    check({tag, ".in_ready"},  in_ready,  e_ready);
    check({tag, ".out_valid"}, out_valid, e_valid);
    check({tag, ".out_data"},  out_data,  e_data);
    check({tag, ".count"},     count,     q.size());
    do_push = in_valid && e_ready;
    do_pop  = e_valid && out_ready;
    @(posedge clk);
    if (rst || flush) q.delete();
    else if (!(pass_thru && out_ready)) begin
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back(in_data);
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    cyc("reset");
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] fill_vals [4];
    fill_vals[0] = 4'h3; fill_vals[1] = 4'h5; fill_vals[2] = 4'h9; fill_vals[3] = 4'hC;

    // Reset then idle.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cyc("idle");
      check("idle.count_const", count, 0);
      check("idle.data_const", out_data, 0);
    end

    // Fill to full, reject an extra word, then drain in order.
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = fill_vals[i];
      cyc("fill");
    end
    check("full.count", count, 4);
    check("full.in_ready", in_ready, 0);
    in_data = 4'hF;
    cyc("full_reject");
    check("full_reject.count", count, 4);
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain.order", out_data, fill_vals[i]);
      cyc("drain");
    end
    check("drain.empty", out_valid, 0);

    // Hold three entries while streaming through with wrap-around.
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 4'(i);
      cyc("prefill");
    end
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      in_data = 4'(k + 3);
      check("stream.out", out_data, k);
      cyc("stream");
      check("stream.count", count, 3);
    end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) cyc("stream_drain");

    // Full FIFO with simultaneous pop request: no write-through, slot reopens next cycle.
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 4'(8 + i);
      cyc("refill");
    end
    out_ready = 1'b1; in_data = 4'hD;
    check("fullpop.in_ready", in_ready, 0);
    cyc("fullpop");
    check("fullpop.count", count, 3);
    check("fullpop.reopen", in_ready, 1);
    out_ready = 1'b0;
    cyc("fullpop_push");
    check("fullpop_push.count", count, 4);

    // Flush drops contents and the coincident push.
    do_reset();
    in_valid = 1'b1; out_ready = 1'b0;
    in_data = 4'h7; cyc("pre_flush");
    in_data = 4'h8; cyc("pre_flush");
    flush = 1'b1; in_data = 4'hA; out_ready = 1'b1;
    cyc("flush");
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    check("flush.count", count, 0);
    check("flush.out_valid", out_valid, 0);
    in_valid = 1'b1; in_data = 4'h1;
    cyc("post_flush_push");
    in_valid = 1'b0;
    check("post_flush.first", out_data, 4'h1);
    out_ready = 1'b1;
    cyc("post_flush_pop");

    // rst and flush together.
    in_valid = 1'b1; out_ready = 1'b0; in_data = 4'h4;
    cyc("pre_both");
    rst = 1'b1; flush = 1'b1;
    cyc("rst_flush");
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    #1;
    check("rst_flush.count", count, 0);

    // Empty FIFO with producer and consumer both active.
    in_valid = 1'b1; out_ready = 1'b1; in_data = 4'h6;
    #1;
    check("byp.out_valid", out_valid, BYP ? 1 : 0);
    check("byp.out_data", out_data, BYP ? 4'h6 : 4'h0);
    cyc("byp");
    in_valid = 1'b0;
    #1;
    check("byp.count_after", count, BYP ? 0 : 1);
    check("byp.next_data", out_data, BYP ? 4'h0 : 4'h6);
    cyc("byp_next");

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_data   = 4'($urandom);
      flush     = ($urandom_range(0, 31) == 0);
      rst       = ($urandom_range(0, 63) == 0);
      cyc("rand");
    end
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
